// File: rtl/sm83_pkg.sv
// Shared types for the SM83 core: decoded control ops and sequencer states.
package sm83_pkg;

  typedef enum logic [2:0] {
    CTL_NOP  = 3'd0,
    CTL_LD   = 3'd1,
    CTL_ALU  = 3'd2,
    CTL_JP   = 3'd3,
    CTL_CALL = 3'd4,
    CTL_RET  = 3'd5,
    CTL_PUSH = 3'd6,
    CTL_POP  = 3'd7
  } ctl_op_t;

  typedef enum logic [1:0] {
    SEQ_FETCH = 2'd0,
    SEQ_EXEC  = 2'd1,
    SEQ_HALT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sm83_tcounter.sv
// T-state counter: counts 0..TPM-1 and holds on the last T-state while the
// memory bus is not ready, so a slow access stretches the M-cycle.
module sm83_tcounter #(
  parameter int TPM = 4,
  parameter int TW  = (TPM > 1) ? $clog2(TPM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_ready,
  output logic [TW-1:0] tstate,
  output logic          m_end
);

  logic [TW-1:0] r_tstate;
  logic          w_last;

  assign w_last = (r_tstate == TW'(TPM - 1));
  assign m_end  = w_last && mem_ready;
  assign tstate = r_tstate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstate <= '0;
    end else if (m_end) begin
      r_tstate <= '0;
    end else if (!w_last) begin
      r_tstate <= r_tstate + TW'(1);
    end
  end

endmodule

// File: rtl/sm83_sequencer.sv
// Fetch/execute M-cycle sequencer for the SM83 core with bus-wait stretching.
// Define SM83_SEQ_HALT_EN to make HALT park the sequencer until irq_pending.
module sm83_sequencer
  import sm83_pkg::*;
#(
  parameter int TPM    = 4,
  parameter int MAX_MC = 6,
  parameter int MCW    = $clog2(MAX_MC + 1),
  parameter int TW     = (TPM > 1) ? $clog2(TPM) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  ctl_op_t        ctl_op,
  input  logic [MCW-1:0] op_mcycles,
  input  logic           halt_op,
  input  logic           mem_ready,
  input  logic           irq_pending,
  output logic           fetch_cycle,
  output logic           execute_cycle,
  output logic           execute_last,
  output logic [MCW-1:0] mcycle,
  output logic [TW-1:0]  tstate,
  output logic           m_end,
  output ctl_op_t        curr_op,
  output logic           halted
);

  seq_state_t     r_state,    w_state_nx;
  logic [MCW-1:0] r_mcycle,   w_mcycle_nx;
  logic [MCW-1:0] r_exec_len, w_exec_len_nx;
  ctl_op_t        r_curr_op,  w_curr_op_nx;
  logic [MCW-1:0] w_len_clamp;
  logic           w_m_end;
  logic           w_last;

  sm83_tcounter #(.TPM(TPM), .TW(TW)) u_tcounter (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ready (mem_ready),
    .tstate    (tstate),
    .m_end     (w_m_end)
  );

  // Decoder may report more M-cycles than the sequencer supports; cap it.
  assign w_len_clamp = (op_mcycles > MCW'(MAX_MC)) ? MCW'(MAX_MC) : op_mcycles;
  assign w_last      = (r_mcycle == (r_exec_len - MCW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEQ_FETCH;
      r_mcycle   <= '0;
      r_exec_len <= '0;
      r_curr_op  <= CTL_NOP;
    end else begin
      r_state    <= w_state_nx;
      r_mcycle   <= w_mcycle_nx;
      r_exec_len <= w_exec_len_nx;
      r_curr_op  <= w_curr_op_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_mcycle_nx   = r_mcycle;
    w_exec_len_nx = r_exec_len;
    w_curr_op_nx  = r_curr_op;
    case (r_state)
      SEQ_FETCH: begin
        if (w_m_end) begin
          w_curr_op_nx  = ctl_op;
          w_exec_len_nx = w_len_clamp;
          w_mcycle_nx   = '0;
`ifdef SM83_SEQ_HALT_EN
          if (halt_op) w_state_nx = SEQ_HALT;
          else
`endif
          if (w_len_clamp != '0) w_state_nx = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (w_m_end) begin
          if (w_last) begin
            w_state_nx  = SEQ_FETCH;
            w_mcycle_nx = '0;
          end else begin
            w_mcycle_nx = r_mcycle + MCW'(1);
          end
        end
      end
      SEQ_HALT: begin
`ifdef SM83_SEQ_HALT_EN
        if (w_m_end && irq_pending) w_state_nx = SEQ_FETCH;
`else
        w_state_nx = SEQ_FETCH;
`endif
      end
      default: w_state_nx = SEQ_FETCH;
    endcase
  end

  assign fetch_cycle   = (r_state == SEQ_FETCH);
  assign execute_cycle = (r_state == SEQ_EXEC);
  assign execute_last  = (r_state == SEQ_EXEC) && w_last;
  assign mcycle        = r_mcycle;
  assign m_end         = w_m_end;
  assign curr_op       = r_curr_op;

`ifdef SM83_SEQ_HALT_EN
  assign halted = (r_state == SEQ_HALT);
`else
  // HALT support compiled out: these inputs have no effect.
  logic w_unused_halt;
  assign w_unused_halt = halt_op ^ irq_pending;
  assign halted        = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_sequencer.sv
// Bench for sm83_sequencer: directed timing scenarios then random stimulus,
// compared every clock against a counting model of the sequencer.
module tb_sm83_sequencer;
  import sm83_pkg::*;

  localparam int TPM    = 4;
  localparam int MAX_MC = 6;
  localparam int MCW    = $clog2(MAX_MC + 1);
  localparam int TW     = 2;
`ifdef SM83_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  ctl_op_t        ctl_op;
  logic [MCW-1:0] op_mcycles;
  logic           halt_op, mem_ready, irq_pending;
  logic           fetch_cycle, execute_cycle, execute_last, m_end, halted;
  logic [MCW-1:0] mcycle;
  logic [TW-1:0]  tstate;
  ctl_op_t        curr_op;

  always #5 clk = ~clk;

  sm83_sequencer #(.TPM(TPM), .MAX_MC(MAX_MC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctl_op        (ctl_op),
    .op_mcycles    (op_mcycles),
    .halt_op       (halt_op),
    .mem_ready     (mem_ready),
    .irq_pending   (irq_pending),
    .fetch_cycle   (fetch_cycle),
    .execute_cycle (execute_cycle),
    .execute_last  (execute_last),
    .mcycle        (mcycle),
    .tstate        (tstate),
    .m_end         (m_end),
    .curr_op       (curr_op),
    .halted        (halted)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: position in M-cycle, execute M-cycles still to run, halt flag.
  int m_t, m_rem, m_len, m_op;
  bit m_hlt;

  function automatic void model_reset();
    m_t = 0; m_rem = 0; m_len = 0; m_op = 0; m_hlt = 1'b0;
  endfunction

  // Called at a negedge: drive inputs, compare, advance model over the posedge.
  task automatic step(input bit mr, input int opc, input int opm, input bit hop, input bit irq);
    bit exp_mend;
    mem_ready   = mr;
    ctl_op      = ctl_op_t'(opc[2:0]);
    op_mcycles  = opm[MCW-1:0];
    halt_op     = hop;
    irq_pending = irq;
    #1;
    if (!rst_n) model_reset();
    exp_mend = (m_t == TPM - 1) && mr;
    check("tstate",        int'(tstate),        m_t);
    check("m_end",         int'(m_end),         int'(exp_mend));
    check("fetch_cycle",   int'(fetch_cycle),   int'(m_rem == 0 && !m_hlt));
    check("execute_cycle", int'(execute_cycle), int'(m_rem > 0));
    check("execute_last",  int'(execute_last),  int'(m_rem == 1));
    check("mcycle",        int'(mcycle),        (m_rem > 0) ? (m_len - m_rem) : 0);
    check("halted",        int'(halted),        int'(m_hlt));
    check("curr_op",       int'(curr_op),       m_op);
    @(posedge clk);
    if (rst_n) begin
      if (exp_mend) begin
        m_t = 0;
        if (m_hlt) begin
          if (irq) m_hlt = 1'b0;
        end else if (m_rem > 0) begin
          m_rem--;
        end else begin
          m_op  = opc & 7;
          m_len = (opm > MAX_MC) ? MAX_MC : opm;
          if (HALT_EN && hop) m_hlt = 1'b1;
          else m_rem = m_len;
        end
      end else if (m_t < TPM - 1) begin
        m_t++;
      end
    end
    @(negedge clk);
  endtask

  // One instruction from fetch T0; returns number of non-fetch clocks seen.
  task automatic run_op(input int opc, input int opm, input int stall_n, output int cnt);
    int stalls;
    bit mr;
    cnt = 0;
    stalls = 0;
    for (int i = 0; i < TPM; i++) step(1'b1, opc, opm, 1'b0, 1'b0);
    for (int k = 0; k < 400 && fetch_cycle !== 1'b1; k++) begin
      mr = 1'b1;
      if (mcycle == '0 && tstate == TW'(TPM - 1) && stalls < stall_n) begin
        mr = 1'b0;
        stalls++;
      end
      cnt++;
      step(mr, 0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    mem_ready = 1'b1; ctl_op = CTL_NOP; op_mcycles = '0; halt_op = 1'b0; irq_pending = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Back-to-back fetch-only ops.
    for (int i = 0; i < 4 * TPM; i++) step(1'b1, i / TPM + 1, 0, 1'b0, 1'b0);

    run_op(2, 3, 0, cnt);
    check("exec_clks_3", cnt, 3 * TPM);
    run_op(3, 3, 3, cnt);
    check("exec_clks_3_wait3", cnt, 3 * TPM + 3);
    run_op(4, 7, 0, cnt);
    check("exec_clks_clamp", cnt, MAX_MC * TPM);

    // HALT: pulse irq off m_end (no wake), then hold it through m_end.
    for (int i = 0; i < TPM; i++) step(1'b1, 5, 0, 1'b1, 1'b0);
    check("halt_entered", int'(halted), int'(HALT_EN));
    for (int i = 0; i < TPM; i++) step(1'b1, 0, 0, 1'b0, i == 1);
    check("halt_held", int'(halted), int'(HALT_EN));
    for (int i = 0; i < TPM; i++) step(1'b1, 0, 0, 1'b0, 1'b1);
    check("halt_woke", int'(fetch_cycle), 1);

    // Reset mid execute M-cycle 1 of a 3-cycle op.
    for (int i = 0; i < TPM; i++) step(1'b1, 6, 3, 1'b0, 1'b0);
    for (int k = 0; k < 40 && !(m_rem > 0 && m_len - m_rem == 1 && m_t == 1); k++)
      step(1'b1, 0, 0, 1'b0, 1'b0);
    check("rst_pre_mcycle", int'(mcycle), 1);
    rst_n = 1'b0;
    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_op(7, 2, 0, cnt);
    check("post_rst_exec", cnt, 2 * TPM);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
